// File: rtl/id_ex_operand_stage_pkg.sv
// Shared CPU types for the ID/EX operand stage.
// Contents:
//   XLEN, REG_ADDR_W  - datapath and register-index widths
//   alu_function_t    - ALU operation select
//   id_ex_t           - fields held in the ID/EX stage register
//   ID_EX_RESET       - reset image of id_ex_t (ALU op resets to ADD)
package id_ex_operand_stage_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_function_t;

   typedef struct packed {
      alu_function_t         alu_control;
      logic [REG_ADDR_W-1:0] rs1_addr;
      logic [REG_ADDR_W-1:0] rs2_addr;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
      logic [XLEN-1:0]       imm;
      logic                  use_imm;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic                  reg_write;
      logic                  is_load;
   } id_ex_t;

   localparam id_ex_t ID_EX_RESET = '{
      alu_control: ALU_ADD,
      rs1_addr:    '0,
      rs2_addr:    '0,
      rs1_data:    '0,
      rs2_data:    '0,
      imm:         '0,
      use_imm:     1'b0,
      rd_addr:     '0,
      reg_write:   1'b0,
      is_load:     1'b0
   };

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, forwarding and execute-side signals of the ID/EX operand stage.
// Modports:
//   slave  - the stage: consumes dec_* / forwarding / ex_ready, drives dec_ready / ex_*
//   master - the environment (decode, later stages, execute)
interface id_ex_operand_stage_if;
   import id_ex_operand_stage_pkg::*;

   // decode offer
   logic                  dec_valid;
   logic                  dec_ready;
   alu_function_t         dec_alu_control;
   logic [REG_ADDR_W-1:0] dec_rs1_addr;
   logic [REG_ADDR_W-1:0] dec_rs2_addr;
   logic [XLEN-1:0]       dec_rs1_data;
   logic [XLEN-1:0]       dec_rs2_data;
   logic [XLEN-1:0]       dec_imm;
   logic                  dec_use_imm;
   logic [REG_ADDR_W-1:0] dec_rd_addr;
   logic                  dec_reg_write;
   logic                  dec_is_load;

   // forwarding sources
   logic [REG_ADDR_W-1:0] exmem_rd_addr;
   logic                  exmem_reg_write;
   logic                  exmem_is_load;
   logic [XLEN-1:0]       exmem_result;
   logic [REG_ADDR_W-1:0] memwb_rd_addr;
   logic                  memwb_reg_write;
   logic [XLEN-1:0]       memwb_result;

   // execute side
   logic                  ex_valid;
   logic                  ex_ready;
   alu_function_t         ex_alu_control;
   logic [XLEN-1:0]       ex_a;
   logic [XLEN-1:0]       ex_b;
   logic [XLEN-1:0]       ex_store_data;
   logic [REG_ADDR_W-1:0] ex_rd_addr;
   logic                  ex_reg_write;
   logic                  ex_is_load;

   modport slave (
      input  dec_valid, dec_alu_control, dec_rs1_addr, dec_rs2_addr,
             dec_rs1_data, dec_rs2_data, dec_imm, dec_use_imm,
             dec_rd_addr, dec_reg_write, dec_is_load,
      output dec_ready,
      input  exmem_rd_addr, exmem_reg_write, exmem_is_load, exmem_result,
             memwb_rd_addr, memwb_reg_write, memwb_result,
      output ex_valid, ex_alu_control, ex_a, ex_b, ex_store_data,
             ex_rd_addr, ex_reg_write, ex_is_load,
      input  ex_ready
   );

   modport master (
      output dec_valid, dec_alu_control, dec_rs1_addr, dec_rs2_addr,
             dec_rs1_data, dec_rs2_data, dec_imm, dec_use_imm,
             dec_rd_addr, dec_reg_write, dec_is_load,
      input  dec_ready,
      output exmem_rd_addr, exmem_reg_write, exmem_is_load, exmem_result,
             memwb_rd_addr, memwb_reg_write, memwb_result,
      input  ex_valid, ex_alu_control, ex_a, ex_b, ex_store_data,
             ex_rd_addr, ex_reg_write, ex_is_load,
      output ex_ready
   );

endinterface

// File: rtl/id_ex_operand_stage_forward_select.sv
// Forwarding priority mux for one source operand.
// Ports:
//   i_rs_addr / i_rs_data          - held source index and register-file value
//   i_exmem_*                      - EX/MEM forwarding source (highest priority)
//   i_memwb_*                      - MEM/WB forwarding source
//   o_data                         - forwarded operand value
// Index 0 is hard-wired zero and is never forwarded.
module id_ex_operand_stage_forward_select
   import id_ex_operand_stage_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] i_rs_addr,
   input  logic [XLEN-1:0]       i_rs_data,
   input  logic [REG_ADDR_W-1:0] i_exmem_rd_addr,
   input  logic                  i_exmem_reg_write,
   input  logic [XLEN-1:0]       i_exmem_result,
   input  logic [REG_ADDR_W-1:0] i_memwb_rd_addr,
   input  logic                  i_memwb_reg_write,
   input  logic [XLEN-1:0]       i_memwb_result,
   output logic [XLEN-1:0]       o_data
);

   logic w_rs_nonzero;

   assign w_rs_nonzero = (i_rs_addr != '0);

   always_comb begin
      o_data = i_rs_data;
      if (w_rs_nonzero && i_exmem_reg_write && (i_exmem_rd_addr == i_rs_addr)) begin
         o_data = i_exmem_result;
      end else if (w_rs_nonzero && i_memwb_reg_write && (i_memwb_rd_addr == i_rs_addr)) begin
         o_data = i_memwb_result;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   flush  - kill the held instruction on the next edge
//   bus    - decode offer, forwarding sources and execute handshake (slave view)
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   id_ex_operand_stage_if.slave bus
);

   id_ex_t          r_stage;
   logic            r_stage_valid;

   logic            w_hazard;
   logic            w_ex_valid;
   logic            w_ex_fire;
   logic            w_dec_ready;
   logic            w_accept;
   logic [XLEN-1:0] w_rs1_fwd;
   logic [XLEN-1:0] w_rs2_fwd;

   // rs2 is conservatively treated as always read, so a load into either
   // source register stalls regardless of use_imm.
   assign w_hazard = r_stage_valid && bus.exmem_is_load && bus.exmem_reg_write &&
                     (bus.exmem_rd_addr != '0) &&
                     ((bus.exmem_rd_addr == r_stage.rs1_addr) ||
                      (bus.exmem_rd_addr == r_stage.rs2_addr));

   assign w_ex_valid  = r_stage_valid && !w_hazard;
   assign w_ex_fire   = w_ex_valid && bus.ex_ready;
   assign w_dec_ready = !r_stage_valid || w_ex_fire;
   assign w_accept    = bus.dec_valid && w_dec_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage_valid <= 1'b0;
         r_stage       <= ID_EX_RESET;
      end else if (flush) begin
         r_stage_valid <= 1'b0;
      end else if (w_accept) begin
         r_stage_valid <= 1'b1;
         r_stage       <= '{
            alu_control: bus.dec_alu_control,
            rs1_addr:    bus.dec_rs1_addr,
            rs2_addr:    bus.dec_rs2_addr,
            rs1_data:    bus.dec_rs1_data,
            rs2_data:    bus.dec_rs2_data,
            imm:         bus.dec_imm,
            use_imm:     bus.dec_use_imm,
            rd_addr:     bus.dec_rd_addr,
            reg_write:   bus.dec_reg_write,
            is_load:     bus.dec_is_load
         };
      end else if (w_ex_fire) begin
         r_stage_valid <= 1'b0;
      end
   end

   id_ex_operand_stage_forward_select u_fwd_rs1 (
      .i_rs_addr         (r_stage.rs1_addr),
      .i_rs_data         (r_stage.rs1_data),
      .i_exmem_rd_addr   (bus.exmem_rd_addr),
      .i_exmem_reg_write (bus.exmem_reg_write),
      .i_exmem_result    (bus.exmem_result),
      .i_memwb_rd_addr   (bus.memwb_rd_addr),
      .i_memwb_reg_write (bus.memwb_reg_write),
      .i_memwb_result    (bus.memwb_result),
      .o_data            (w_rs1_fwd)
   );

   id_ex_operand_stage_forward_select u_fwd_rs2 (
      .i_rs_addr         (r_stage.rs2_addr),
      .i_rs_data         (r_stage.rs2_data),
      .i_exmem_rd_addr   (bus.exmem_rd_addr),
      .i_exmem_reg_write (bus.exmem_reg_write),
      .i_exmem_result    (bus.exmem_result),
      .i_memwb_rd_addr   (bus.memwb_rd_addr),
      .i_memwb_reg_write (bus.memwb_reg_write),
      .i_memwb_result    (bus.memwb_result),
      .o_data            (w_rs2_fwd)
   );

   assign bus.dec_ready      = w_dec_ready;
   assign bus.ex_valid       = w_ex_valid;
   assign bus.ex_alu_control = r_stage.alu_control;
   assign bus.ex_a           = w_rs1_fwd;
   assign bus.ex_b           = r_stage.use_imm ? r_stage.imm : w_rs2_fwd;
   assign bus.ex_store_data  = w_rs2_fwd;
   assign bus.ex_rd_addr     = r_stage.rd_addr;
   assign bus.ex_reg_write   = r_stage.reg_write;
   assign bus.ex_is_load     = r_stage.is_load;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline register between decode and the execute-stage ALU.
- Captures the decoded operation, operand values, immediate and destination.
- Resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, and inserts a bubble on load-use.
- Presents the final ALU operands a/b and the alu_function_t select to execute over a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the held instruction (branch/jump redirect).
- dec_valid  in  1  decode offers an instruction.
- dec_ready  out  1  stage accepts this cycle.
- dec_alu_control  in  alu_function_t  ALU operation.
- dec_rs1_addr, dec_rs2_addr  in  REG_ADDR_W  source indices.
- dec_rs1_data, dec_rs2_data  in  XLEN  register-file read values.
- dec_imm  in  XLEN  sign-extended immediate.
- dec_use_imm  in  1  b operand is the immediate.
- dec_rd_addr  in  REG_ADDR_W  destination index.
- dec_reg_write  in  1  instruction writes rd.
- dec_is_load  in  1  instruction is a load.
- exmem_rd_addr  in  REG_ADDR_W, exmem_reg_write  in  1, exmem_is_load  in  1, exmem_result  in  XLEN  EX/MEM forwarding source.
- memwb_rd_addr  in  REG_ADDR_W, memwb_reg_write  in  1, memwb_result  in  XLEN  MEM/WB forwarding source.
- ex_valid  out  1  operands valid for execute.
- ex_ready  in  1  execute consumes.
- ex_alu_control  out  alu_function_t.
- ex_a, ex_b  out  XLEN  final ALU operands.
- ex_store_data  out  XLEN  forwarded rs2.
- ex_rd_addr  out  REG_ADDR_W, ex_reg_write  out  1, ex_is_load  out  1.

Behaviour:
- One stage register plus a held flag, stage_valid.
- Reset (rst_n low, asynchronous):
  - stage_valid=0; all held fields 0; alu_control resets to ADD.
  - Consequently ex_valid=0 and ex_a/ex_b/ex_store_data=0.
  - Reset mid-operation discards the held instruction.
- Handshake:
  - ex_fire = ex_valid & ex_ready.
  - dec_ready = !stage_valid | ex_fire (combinational).
  - Accept = dec_valid & dec_ready, which loads all dec_* fields next edge and sets stage_valid=1.
  - ex_fire without accept clears stage_valid.
  - Held fields are unchanged while stalled.
- Flush: takes priority over everything. On the next edge stage_valid=0 whatever dec_valid, ex_fire or hazard are. dec_ready is unaffected by flush.
- Forwarding (combinational from held rs addresses, per operand):
  - Match on EX/MEM when exmem_reg_write & exmem_rd_addr==rs & rs!=0, and use exmem_result.
  - Otherwise match on MEM/WB the same way (memwb_reg_write, memwb_rd_addr), and use memwb_result.
  - Otherwise use the held register data.
  - EX/MEM has priority over MEM/WB. Index 0 is never forwarded.
- Load-use hazard = stage_valid & exmem_is_load & exmem_reg_write & exmem_rd_addr!=0 & (exmem_rd_addr==rs1 | (exmem_rd_addr==rs2 & (!use_imm | held instruction is a store-like rs2 user))).
  - Simplification: rs2 is treated as used always.
  - ex_valid = stage_valid & !hazard, which gives a 1-cycle bubble. The instruction is held and dec_ready=0.
- Operands:
  - ex_a = forwarded rs1.
  - ex_b = use_imm ? imm : forwarded rs2.
  - ex_store_data = forwarded rs2.
- Latency: an instruction accepted at edge N presents ex_valid at N+1 unless there is a hazard. Full throughput is 1/cycle when ex_ready=1.
- Simultaneous accept and fire: the register is overwritten; stage_valid stays 1.

Decomposition:
- cpu_package (existing): alu_function_t.
- Add to cpu_package: XLEN and REG_ADDR_W constants, and a typedef struct id_ex_t bundling the held fields.
- One sub-module, forward_select: one operand's priority mux (rs addr, held data, two sources). Instantiate it twice.

Test Plan:
- Reset then dec_valid=1, ADD, rs1_data=5, rs2_data=7, rd=3, ex_ready=1 -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_alu_control=ADD, rd=3; during reset ex_valid=0.
- Held rs1=4 with exmem_rd=4 (exmem_result=0xAA) and memwb_rd=4 (memwb_result=0xBB) both writing -> ex_a=0xAA. Then drop exmem_reg_write -> ex_a=0xBB.
- Held rs1=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFFFF -> ex_a equals held data (0).
- exmem_is_load=1, exmem_rd=6, held rs2=6 -> ex_valid=0 and dec_ready=0 for that cycle. Next cycle exmem clears, memwb_rd=6, memwb_result=0x1234 -> ex_valid=1, ex_b=0x1234.
- ex_ready=0 for 3 cycles with dec_valid=1 -> dec_ready=0 and held fields stable. Raise ex_ready -> the next instruction loads on the same edge the old one fires.
- flush=1 coincident with dec_valid=1 -> next cycle ex_valid=0. Assert rst_n low mid-stall -> ex_valid=0 immediately (asynchronous).
